// File: rtl/seq_digit_mac_if.sv
// Operand/result bundle for seq_digit_mac: master drives operands and control,
// slave returns status, product and accumulator.
interface seq_digit_mac_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ACC_W = 20
);
   logic                 start;
   logic                 acc_en;
   logic                 clear;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [ACC_W-1:0]     acc;
   logic                 acc_ovf;

   modport master (
      output start, acc_en, clear, a, b,
      input  busy, done, product, acc, acc_ovf
   );

   modport slave (
      input  start, acc_en, clear, a, b,
      output busy, done, product, acc, acc_ovf
   );
endinterface

// File: rtl/seq_digit_mac.sv
// Sequential digit-serial multiplier feeding a wrapping accumulator (MAC stage).
// One DIGIT x DIGIT partial product is summed per cycle over all N*N digit pairs.
module seq_digit_mac #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2,
   parameter int unsigned ACC_W = 20
) (
   input logic            clk,
   input logic            rst,
   seq_digit_mac_if.slave bus
);
   localparam int unsigned N     = WIDTH / DIGIT;
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               acc_en_q, acc_en_d;
   logic [CNT_W-1:0]   i_q, i_d;
   logic [CNT_W-1:0]   j_q, j_d;
   logic [PW-1:0]      product_q, product_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic               acc_ovf_q, acc_ovf_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [DIGIT-1:0]   a_dig_c;
   logic [DIGIT-1:0]   b_dig_c;
   logic [PW-1:0]      part_c;
   logic [ACC_W:0]     acc_sum_c;
   logic               last_i_c;
   logic               last_j_c;

   // Current digit pair and its weighted partial product
   always_comb begin
      a_dig_c   = DIGIT'(a_q >> (DIGIT * 32'(i_q)));
      b_dig_c   = DIGIT'(b_q >> (DIGIT * 32'(j_q)));
      part_c    = (PW'(a_dig_c) * PW'(b_dig_c)) << (DIGIT * (32'(i_q) + 32'(j_q)));
      acc_sum_c = {1'b0, acc_q} + (ACC_W + 1)'(product_q);
      last_i_c  = (i_q == CNT_W'(N - 1));
      last_j_c  = (j_q == CNT_W'(N - 1));
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_en_d  = acc_en_q;
      i_d       = i_q;
      j_d       = j_q;
      product_d = product_q;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      done_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Clear is applied before start so a combined request accumulates onto zero
            if (bus.clear) begin
               acc_d     = '0;
               acc_ovf_d = 1'b0;
            end
            if (bus.start) begin
               a_d       = bus.a;
               b_d       = bus.b;
               acc_en_d  = bus.acc_en;
               product_d = '0;
               i_d       = '0;
               j_d       = '0;
               state_d   = S_MUL;
            end
         end
         S_MUL: begin
            product_d = product_q + part_c;
            if (last_j_c) begin
               j_d = '0;
               if (last_i_c) begin
                  i_d     = '0;
                  state_d = S_ACC;
               end else begin
                  i_d = i_q + CNT_W'(1);
               end
            end else begin
               j_d = j_q + CNT_W'(1);
            end
         end
         S_ACC: begin
            if (acc_en_q) begin
               acc_d = acc_sum_c[ACC_W-1:0];
               if (acc_sum_c[ACC_W]) begin
                  acc_ovf_d = 1'b1;
               end
            end else begin
               acc_d = ACC_W'(product_q);
            end
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         acc_en_q  <= 1'b0;
         i_q       <= '0;
         j_q       <= '0;
         product_q <= '0;
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_en_q  <= acc_en_d;
         i_q       <= i_d;
         j_q       <= j_d;
         product_q <= product_d;
         acc_q     <= acc_d;
         acc_ovf_q <= acc_ovf_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
   assign bus.acc     = acc_q;
   assign bus.acc_ovf = acc_ovf_q;
endmodule
